staircase_monitor: RTL
======================

// Module: staircase_monitor
// PURPOSE
//   Receive-side checker for the staircase counter stream: 0..1, 0..2, ... 0..MAX_RAMP, then back to 0..1.
//   Samples the 4-bit count bus and locks onto the ramp sequence.
//   Once locked, reports the current ramp ceiling, end-of-ramp and end-of-cycle pulses,
//   and flags/counts any deviation.
//   Sits on the consumer side of the counter, in the same clock domain; used in-system and as a bench scoreboard.
// PARAMETERS
//   MAX_RAMP    9  highest ramp ceiling; legal range 1..15; the ramp after ceiling MAX_RAMP has ceiling 1
//   LOCK_RAMPS  2  number of consecutive error-free complete ramps in CONFIRM before locked asserts; minimum 1
//   ERR_CNT_W   8  width of the saturating error counter
// PORTS
//   clk          in   1          clock, rising edge
//   rst          in   1          asynchronous, active-high reset
//   in_valid     in   1          count_in is sampled only on cycles where this is 1
//   count_in     in   4          observed counter value
//   locked       out  1          1 while in LOCKED state
//   cur_max      out  4          ceiling of the ramp in progress; valid only when locked=1
//   ramp_done    out  1          1-cycle pulse: accepted sample equalled the expected ceiling (CONFIRM or LOCKED)
//   cycle_done   out  1          1-cycle pulse: ramp_done for the ramp with ceiling MAX_RAMP
//   err          out  1          1-cycle pulse: mismatch detected while in LOCKED
//   err_count    out  ERR_CNT_W  number of err pulses, saturates at all-ones
// BEHAVIOUR
//   Reset (async, rst=1): state=HUNT; prev_v=0; exp=0; max=0; ramps=0.
//     Outputs on reset: locked=0, cur_max=0, ramp_done=0, cycle_done=0, err=0, err_count=0.
//   Timing:
//     - Outputs are registered.
//     - The response to a sample accepted at edge N is visible after edge N (one-cycle latency).
//     - With in_valid=0, no state or register changes, and all pulses are 0.
//   nxt(m) = (m == MAX_RAMP) ? 1 : m+1. All compares are 4-bit unsigned.
//   HUNT:
//     - Each accepted sample s is stored: prev_v <= 1, prev <= s.
//     - If s==0, prev_v==1, and 1 <= prev <= MAX_RAMP:
//       max <= nxt(prev); exp <= 1; ramps <= 0; go to CONFIRM.
//     - Otherwise stay in HUNT. A 0 following a 0, or following a value > MAX_RAMP, gives no lock.
//   CONFIRM / LOCKED, for accepted sample s:
//     - s==exp and exp<max:
//       exp <= exp+1.
//     - s==exp and exp==max:
//       exp <= 0; max <= nxt(max); ramp_done=1; cycle_done=(max==MAX_RAMP).
//       In CONFIRM: ramps <= ramps+1; if ramps+1==LOCK_RAMPS, go to LOCKED.
//     - s!=exp in CONFIRM:
//       go to HUNT with prev_v <= 1, prev <= s. No err pulse.
//     - s!=exp in LOCKED:
//       err=1; err_count <= sat(err_count+1); go to HUNT with prev_v <= 1, prev <= s.
//       locked drops on the same edge.
//   cur_max = max when locked, else 0.
//   Boundary cases:
//     - The ceiling wraps MAX_RAMP->1.
//     - err_count holds at 2^ERR_CNT_W-1.
//     - A mismatching sample that is itself 0 can start re-acquisition on the very next accepted sample only.
//       It is treated as prev, so no instant relock.
//     - rst asserted mid-ramp returns to HUNT immediately. err_count clears.
// TESTING
//   1. Reset, then feed the ideal stream from the counter's reset (0,1,0,1,2,0..3,...), in_valid=1.
//      -> HUNT until sample 3 (the 0 after 1).
//      -> locked rises after 2 complete ramps (ceilings 2,3), with cur_max=4.
//      -> err stays 0.
//   2. Continue the locked stream through ceiling 9.
//      -> cycle_done pulses exactly once, on the sample 9.
//      -> The next ramp gives cur_max=1, and the stream 0,1 gives ramp_done.
//   3. When locked with ceiling 5, inject 7 in place of 3.
//      -> err pulses one cycle, err_count=1, locked=0.
//      -> Relock on the subsequent clean ramps.
//   4. Toggle in_valid=0 on random cycles during an ideal stream.
//      -> Identical lock/pulse sequence in sample order, with no err.
//   5. ERR_CNT_W=2: inject 5 errors with a relock between each.
//      -> err_count goes 1,2,3,3,3.
//   6. Assert rst while locked mid-ramp.
//      -> All outputs are 0 immediately (asynchronously).
//      -> Re-acquisition follows the HUNT rules after release.

Source files
------------

// File: rtl/staircase_monitor.sv
// Receive-side checker for the staircase counter stream (0..1, 0..2, ... 0..MAX_RAMP, repeat).
// Locks onto the ramp sequence, reports ramp/cycle ends and counts deviations once locked.
module staircase_monitor #(
  parameter int MAX_RAMP   = 9,
  parameter int LOCK_RAMPS = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [3:0]           count_in,
  output logic                 locked,
  output logic [3:0]           cur_max,
  output logic                 ramp_done,
  output logic                 cycle_done,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] CONFIRM = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  localparam int          RW     = (LOCK_RAMPS < 2) ? 1 : $clog2(LOCK_RAMPS + 1);
  localparam logic [3:0]  MAX_V  = 4'(MAX_RAMP);
  localparam logic [RW-1:0] LOCK_V = RW'(LOCK_RAMPS);

  logic [1:0]           state_q, state_d;
  logic                 prev_v_q, prev_v_d;
  logic [3:0]           prev_q, prev_d;
  logic [3:0]           exp_q, exp_d;
  logic [3:0]           max_q, max_d;
  logic [RW-1:0]        ramps_q, ramps_d;
  logic                 ramp_done_q, ramp_done_d;
  logic                 cycle_done_q, cycle_done_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  function automatic logic [3:0] nxt(input logic [3:0] m);
    return (m == MAX_V) ? 4'd1 : m + 4'd1;
  endfunction

  always_comb begin
    state_d      = state_q;
    prev_v_d     = prev_v_q;
    prev_d       = prev_q;
    exp_d        = exp_q;
    max_d        = max_q;
    ramps_d      = ramps_q;
    err_count_d  = err_count_q;
    ramp_done_d  = 1'b0;
    cycle_done_d = 1'b0;
    err_d        = 1'b0;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          prev_v_d = 1'b1;
          prev_d   = count_in;
          // A 0 directly after a plausible ceiling marks the start of the next ramp.
          if (count_in == 4'd0 && prev_v_q && prev_q >= 4'd1 && prev_q <= MAX_V) begin
            max_d   = nxt(prev_q);
            exp_d   = 4'd1;
            ramps_d = '0;
            state_d = CONFIRM;
          end
        end
        CONFIRM, LOCKED: begin
          if (count_in == exp_q) begin
            if (exp_q < max_q) begin
              exp_d = exp_q + 4'd1;
            end else begin
              exp_d        = 4'd0;
              max_d        = nxt(max_q);
              ramp_done_d  = 1'b1;
              cycle_done_d = (max_q == MAX_V);
              if (state_q == CONFIRM) begin
                ramps_d = ramps_q + RW'(1);
                if (ramps_q + RW'(1) == LOCK_V) state_d = LOCKED;
              end
            end
          end else begin
            // The mismatching sample becomes the HUNT history, so re-lock needs a further 0.
            if (state_q == LOCKED) begin
              err_d = 1'b1;
              if (err_count_q != '1) err_count_d = err_count_q + ERR_CNT_W'(1);
            end
            state_d  = HUNT;
            prev_v_d = 1'b1;
            prev_d   = count_in;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      prev_v_q     <= 1'b0;
      prev_q       <= 4'd0;
      exp_q        <= 4'd0;
      max_q        <= 4'd0;
      ramps_q      <= '0;
      ramp_done_q  <= 1'b0;
      cycle_done_q <= 1'b0;
      err_q        <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      prev_v_q     <= prev_v_d;
      prev_q       <= prev_d;
      exp_q        <= exp_d;
      max_q        <= max_d;
      ramps_q      <= ramps_d;
      ramp_done_q  <= ramp_done_d;
      cycle_done_q <= cycle_done_d;
      err_q        <= err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign cur_max    = locked ? max_q : 4'd0;
  assign ramp_done  = ramp_done_q;
  assign cycle_done = cycle_done_q;
  assign err        = err_q;
  assign err_count  = err_count_q;
  assign dbg_state  = state_q;

endmodule
